// File: rtl/bsg_counter_dynamic_limit_down.sv
// ---------------------------------------------------------------------------
// bsg_counter_dynamic_limit_down
//
// Purpose:
//   A down counter with a run-time limit. It loads limit_i, counts down to
//   zero, and then reloads limit_i. With en_i held high and a constant limit
//   L, one period is L+1 cycles, the same as the up-counting dynamic-limit
//   counter. Use it where logic needs "cycles remaining" rather than
//   "cycles elapsed" (timers, credit return, frame spacing).
//
// Parameters:
//   width_p    : counter and limit width in bits (must be 1 or more)
//
// Ports:
//   clk_i      : clock; all state changes on its rising edge
//   reset_i    : synchronous, active-high reset; loads limit_i
//   en_i       : count enable; the counter holds while this is low
//   start_i    : immediate reload from limit_i; takes priority over en_i
//   limit_i    : reload value; sampled only on reset, start or reload-at-zero
//   counter_o  : current count (cycles remaining)
//   zero_o     : high when counter_o == 0 (decoded from state only)
//   wrap_o     : registered; high in the cycle that first shows a value
//                reloaded at zero
//
// Configuration macro:
//   BSG_COUNTER_DYNAMIC_LIMIT_DOWN_ONESHOT_EN
//     undefined : free-running; at zero with en_i the counter reloads
//                 limit_i and wrap_o pulses
//     defined   : one-shot; at zero the counter stays at 0, an internal
//                 done flag sets, and wrap_o is never asserted. Only
//                 start_i or reset_i rearms the counter.
// ---------------------------------------------------------------------------

module bsg_counter_dynamic_limit_down #(
  parameter int width_p = 128
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               start_i,
  input  logic [width_p-1:0] limit_i,
  output logic [width_p-1:0] counter_o,
  output logic               zero_o,
  output logic               wrap_o
);

  localparam logic [width_p-1:0] one_lp  = width_p'(1);
  localparam logic [width_p-1:0] zero_lp = '0;

  logic [width_p-1:0] counter_q, counter_d;
  logic               wrap_q,    wrap_d;
  logic               at_zero;

  // The count is never compared against limit_i. A limit change takes
  // effect only at the next load, so a run in progress always finishes
  // with the limit it started with.
  assign at_zero = (counter_q == zero_lp);

`ifdef BSG_COUNTER_DYNAMIC_LIMIT_DOWN_ONESHOT_EN

  logic done_q, done_d;

  always_comb begin
    counter_d = counter_q;
    wrap_d    = 1'b0;
    done_d    = done_q;

    if (reset_i || start_i) begin
      counter_d = limit_i;
      done_d    = 1'b0;
    end else if (en_i) begin
      if (!at_zero) begin
        counter_d = counter_q - one_lp;
      end else if (!done_q) begin
        // Expiry: park at zero. Only start or reset rearms the counter.
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    done_q <= done_d;
  end

`else

  always_comb begin
    counter_d = counter_q;
    wrap_d    = 1'b0;

    if (reset_i || start_i) begin
      counter_d = limit_i;
    end else if (en_i) begin
      if (!at_zero) begin
        // Decrement only when nonzero, so the subtract can never underflow.
        counter_d = counter_q - one_lp;
      end else begin
        counter_d = limit_i;
        wrap_d    = 1'b1;
      end
    end
  end

`endif

  // The reset value comes from limit_i, so reset is simply the
  // highest-priority load in the next-state logic above.
  always_ff @(posedge clk_i) begin
    counter_q <= counter_d;
    wrap_q    <= wrap_d;
  end

  assign counter_o = counter_q;
  assign zero_o    = at_zero;
  assign wrap_o    = wrap_q;

endmodule
